// File: rtl/gray_timer_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : gray_timer_reader_if
// Purpose  : Timer-reader bus: Gray input, capture stream and status.
// Revision : 1.0
// ============================================================================
interface gray_timer_reader_if #(
   parameter int NIB = 5,
   parameter int EPW = 8
);
   localparam int c_cw = 4 * NIB;

   logic [c_cw-1:0]     gray_in;
   logic                tcc_in;
   logic                cap_req;
   logic [c_cw-1:0]     cmp_val;
   logic                cap_valid;
   logic                cap_ready;
   logic [EPW+c_cw-1:0] cap_data;
   logic [c_cw-1:0]     bin_out;
   logic                match;
   logic                ovf;
   logic                ovf_clr;

   modport slave (
      input  gray_in, tcc_in, cap_req, cmp_val, cap_ready, ovf_clr,
      output cap_valid, cap_data, bin_out, match, ovf
   );

   modport master (
      output gray_in, tcc_in, cap_req, cmp_val, cap_ready, ovf_clr,
      input  cap_valid, cap_data, bin_out, match, ovf
   );
endinterface
`default_nettype wire

// File: rtl/gray_timer_reader.sv
`default_nettype none
// ============================================================================
// Module   : gray_timer_reader
// Purpose  : Decodes nibble-Gray timer, counts wrap epochs, time-stamps captures.
// Revision : 1.0
// ============================================================================
module gray_timer_reader #(
   parameter int NIB   = 5,
   parameter int EPW   = 8,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               clr,
   gray_timer_reader_if.slave bus
);
   localparam int            c_cw   = 4 * NIB;
   localparam int            c_dw   = EPW + c_cw;
   localparam int            c_aw   = $clog2(DEPTH);
   localparam logic [c_aw:0] c_full = (c_aw+1)'(DEPTH);

   logic [c_cw-1:0] r_g_q;
   logic            r_c_q;
   logic [EPW-1:0]  r_e_q;
   logic            r_t_q;
   logic [EPW-1:0]  r_epoch;
   logic [c_cw-1:0] w_bin;
   logic [c_cw-1:0] r_bin;
   logic            r_push;
   logic [c_dw-1:0] r_pdata;
   logic            r_eq_prev;
   logic            r_match;
   logic            r_ovf;

   logic [c_dw-1:0] r_mem [DEPTH];
   logic [c_aw-1:0] r_wptr;
   logic [c_aw-1:0] r_rptr;
   logic [c_aw:0]   r_cnt;
   logic            w_valid;
   logic            w_full;
   logic            w_pop;
   logic            w_wr;
   logic            w_drop;
   logic            w_eq;

   // Each nibble is its own Gray code; bit k of binary is XOR of Gray bits k..3.
   for (genvar i = 0; i < NIB; i++) begin : g_nib
      logic [3:0] w_g;
      assign w_g              = r_g_q[4*i +: 4];
      assign w_bin[4*i +: 4]  = {w_g[3], ^w_g[3:2], ^w_g[3:1], ^w_g[3:0]};
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_g_q   <= '0;
         r_c_q   <= 1'b0;
         r_e_q   <= '0;
         r_t_q   <= 1'b0;
         r_epoch <= '0;
         r_bin   <= '0;
         r_push  <= 1'b0;
         r_pdata <= '0;
      end else begin
         r_g_q   <= bus.gray_in;
         r_c_q   <= bus.cap_req;
         r_e_q   <= r_epoch;
         r_t_q   <= bus.tcc_in;
         if (bus.tcc_in && !r_t_q) begin
            r_epoch <= r_epoch + 1'b1;
         end
         r_bin   <= w_bin;
         r_push  <= r_c_q;
         r_pdata <= {r_e_q, w_bin};
      end
   end

   assign w_valid = (r_cnt != '0);
   assign w_full  = (r_cnt == c_full);
   assign w_pop   = w_valid && bus.cap_ready;
   // A pop frees the head slot this edge, so a full FIFO still accepts the push.
   assign w_wr    = r_push && (!w_full || w_pop);
   assign w_drop  = r_push && w_full && !w_pop;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr) begin
         r_mem[r_wptr] <= r_pdata;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_wr, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // Edge-detect equality so a held match does not re-pulse.
   assign w_eq = (r_bin == bus.cmp_val);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_eq_prev <= 1'b0;
         r_match   <= 1'b0;
      end else begin
         r_eq_prev <= w_eq;
         r_match   <= w_eq && !r_eq_prev;
      end
   end

   assign bus.bin_out   = r_bin;
   assign bus.match     = r_match;
   assign bus.ovf       = r_ovf;
   assign bus.cap_valid = w_valid;
   assign bus.cap_data  = r_mem[r_rptr];
endmodule
`default_nettype wire

// File: tb/tb_gray_timer_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_timer_reader
// Purpose  : Directed scoreboard bench for gray_timer_reader.
// Revision : 1.0
// ============================================================================
module tb_gray_timer_reader;
   logic clk;
   logic clr;
   int   n_checks;
   int   n_fail;
   logic [27:0] exp_q [$];

   gray_timer_reader_if #(.NIB(5), .EPW(8)) bus ();

   gray_timer_reader #(.NIB(5), .EPW(8), .DEPTH(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted FIFO word must match the queue head.
   always @(negedge clk) begin
      if (!clr && bus.cap_valid && bus.cap_ready) begin
         if (exp_q.size() == 0) begin
            chk("cap_unexpected", {36'h0, bus.cap_data}, 64'hDEAD);
         end else begin
            chk("cap_data", {36'h0, bus.cap_data}, {36'h0, exp_q.pop_front()});
         end
      end
   end

   function automatic logic [19:0] enc(input logic [19:0] b);
      logic [19:0] g;
      logic [3:0]  n;
      g = '0;
      for (int i = 0; i < 5; i++) begin
         n            = b[4*i +: 4];
         g[4*i +: 4]  = n ^ (n >> 1);
      end
      return g;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      tick();
      exp_q.delete();
      clr = 1'b0;
   endtask

   task automatic tcc_pulse(input int hi);
      bus.tcc_in = 1'b1;
      repeat (hi) tick();
      bus.tcc_in = 1'b0;
      tick();
   endtask

   task automatic cap(input logic [19:0] g, input logic [27:0] exp, input bit kept);
      bus.gray_in = g;
      bus.cap_req = 1'b1;
      if (kept) exp_q.push_back(exp);
      tick();
      bus.cap_req = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         tick();
         k++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   int bin_cyc;
   int match_cyc;
   int pulses;
   logic [7:0] ep;

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      clr           = 1'b1;
      bus.gray_in   = '0;
      bus.tcc_in    = 1'b0;
      bus.cap_req   = 1'b0;
      bus.cmp_val   = 20'hABCDE;
      bus.cap_ready = 1'b0;
      bus.ovf_clr   = 1'b0;

      // Reset with random activity on the inputs
      repeat (4) begin
         bus.gray_in = 20'($urandom);
         bus.cap_req = 1'($urandom);
         tick();
      end
      chk("rst_bin", 64'(bus.bin_out), 64'd0);
      chk("rst_match", 64'(bus.match), 64'd0);
      chk("rst_valid", 64'(bus.cap_valid), 64'd0);
      chk("rst_data", 64'(bus.cap_data), 64'd0);
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
      bus.cap_req = 1'b0;
      bus.gray_in = 20'h00008;
      clr         = 1'b0;
      tick();
      chk("lat_1edge", 64'(bus.bin_out), 64'd0);
      tick();
      chk("dec_00008", 64'(bus.bin_out), 64'h0000F);
      bus.gray_in = 20'h8C461;
      tick();
      tick();
      chk("dec_8C461", 64'(bus.bin_out), 64'hF8741);

      // Epoch wrap: 254 pulses, then five 3-cycle levels
      bus.cap_ready = 1'b1;
      do_reset();
      repeat (254) tcc_pulse(1);
      cap(enc(20'h00123), {8'd254, 20'h00123}, 1'b1);
      ep = 8'd254;
      for (int k = 0; k < 5; k++) begin
         tcc_pulse(3);
         ep = ep + 8'd1;
         cap(enc(20'h00200 + 20'(k)), {ep, 20'h00200 + 20'(k)}, 1'b1);
      end
      wait_drain();

      // Capture coinciding with a tcc rise keeps the pre-increment epoch
      do_reset();
      repeat (7) tcc_pulse(1);
      bus.gray_in = 20'h13267;
      bus.cap_req = 1'b1;
      bus.tcc_in  = 1'b1;
      exp_q.push_back({8'd7, 20'h12345});
      tick();
      bus.cap_req = 1'b0;
      tick();
      bus.tcc_in = 1'b0;
      tick();
      cap(enc(20'h00042), {8'd8, 20'h00042}, 1'b1);
      wait_drain();

      // FIFO full / overflow / simultaneous push-pop
      do_reset();
      bus.cap_ready = 1'b0;
      cap(enc(20'h11111), {8'd0, 20'h11111}, 1'b1);
      cap(enc(20'h22222), {8'd0, 20'h22222}, 1'b1);
      cap(enc(20'h33333), {8'd0, 20'h33333}, 1'b1);
      cap(enc(20'h44444), {8'd0, 20'h44444}, 1'b1);
      cap(enc(20'h55555), 28'h0, 1'b0);
      repeat (4) tick();
      chk("full_ovf", 64'(bus.ovf), 64'd1);
      chk("full_valid", 64'(bus.cap_valid), 64'd1);
      chk("full_head", 64'(bus.cap_data), 64'h0011111);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      chk("ovf_clr", 64'(bus.ovf), 64'd0);
      bus.gray_in = enc(20'h66666);
      bus.cap_req = 1'b1;
      exp_q.push_back({8'd0, 20'h66666});
      tick();
      bus.cap_req = 1'b0;
      tick();
      bus.cap_ready = 1'b1;
      tick();
      bus.cap_ready = 1'b0;
      repeat (2) tick();
      chk("pushpop_ovf", 64'(bus.ovf), 64'd0);
      cap(enc(20'h77777), 28'h0, 1'b0);
      repeat (3) tick();
      chk("still_full_ovf", 64'(bus.ovf), 64'd1);
      bus.cap_ready = 1'b1;
      repeat (3) tick();
      chk("drain_valid3", 64'(bus.cap_valid), 64'd1);
      tick();
      chk("drain_valid4", 64'(bus.cap_valid), 64'd0);
      wait_drain();

      // Overflow beats ovf_clr on the same edge
      bus.cap_ready = 1'b0;
      cap(enc(20'h00A01), {8'd0, 20'h00A01}, 1'b1);
      cap(enc(20'h00A02), {8'd0, 20'h00A02}, 1'b1);
      cap(enc(20'h00A03), {8'd0, 20'h00A03}, 1'b1);
      cap(enc(20'h00A04), {8'd0, 20'h00A04}, 1'b1);
      cap(enc(20'h00A05), 28'h0, 1'b0);
      tick();
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      chk("ovf_clr_vs_set", 64'(bus.ovf), 64'd1);
      tick();
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      chk("ovf_clr2", 64'(bus.ovf), 64'd0);
      chk("full_before_rst", 64'(bus.cap_valid), 64'd1);
      clr = 1'b1;
      #1;
      chk("midrst_valid", 64'(bus.cap_valid), 64'd0);
      chk("midrst_data", 64'(bus.cap_data), 64'd0);
      exp_q.delete();
      tick();
      clr = 1'b0;
      bus.cap_ready = 1'b1;
      cap(enc(20'h00B0B), {8'd0, 20'h00B0B}, 1'b1);
      wait_drain();

      // Compare match: counter runs 0xC..0x10 then holds
      do_reset();
      bus.cmp_val = 20'h00010;
      bin_cyc     = -1;
      match_cyc   = -1;
      pulses      = 0;
      for (int c = 0; c < 16; c++) begin
         bus.gray_in = enc((c < 4) ? 20'h0000C + 20'(c) : 20'h00010);
         tick();
         if (bus.bin_out == 20'h00010 && bin_cyc < 0) bin_cyc = c;
         if (bus.match) begin
            pulses++;
            if (match_cyc < 0) match_cyc = c;
         end
      end
      chk("match_pulses", 64'(pulses), 64'd1);
      chk("match_timing", 64'(match_cyc), 64'(bin_cyc + 1));
      pulses = 0;
      bus.cmp_val = 20'h00011;
      repeat (2) begin
         tick();
         if (bus.match) pulses++;
      end
      bus.cmp_val = 20'h00010;
      repeat (4) begin
         tick();
         if (bus.match) pulses++;
      end
      chk("cmp_change_pulse", 64'(pulses), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gray_timer_reader.md
Name: gray_timer_reader

Overview:
- Read-side companion of the 20-bit cascaded nibble-Gray timer counter.
- Samples the counter's Gray bus and terminal-count/clear pulse, and decodes each 4-bit Gray nibble to binary to give a live binary count.
- Counts wrap epochs and time-stamps capture events into a small FIFO, which software-side or bus logic drains with a valid/ready handshake.
- Also raises a one-cycle compare-match pulse.

Parameters:
- NIB, 5: number of cascaded 4-bit Gray nibbles; count width CW = 4*NIB.
- EPW, 8: epoch (wrap) counter width.
- DEPTH, 4: capture FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock, same clock as the timer counter.
- clr  in  1  asynchronous active-high reset; one clock; reset is asynchronous and active-high.
- gray_in  in  CW  counter output; nibble i is gray_in[4i+3:4i], each nibble independently Gray-coded.
- tcc_in  in  1  counter terminal-count/clear signal (level; may stay high several cycles).
- cap_req  in  1  capture request, sampled every clk.
- cmp_val  in  CW  binary compare value.
- cap_valid  out  1  FIFO head valid.
- cap_ready  in  1  consumer ready.
- cap_data  out  EPW+CW  {epoch, binary count} at FIFO head.
- bin_out  out  CW  live decoded binary count.
- match  out  1  compare-match pulse.
- ovf  out  1  sticky capture-overflow flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (clr high, asynchronous): all registers 0, so bin_out=0, match=0, cap_valid=0, cap_data=0, ovf=0, epoch=0, FIFO empty.
- Stage 1 (edge N): register gray_in as g_q, cap_req as c_q, and epoch as e_q, using the epoch value before any increment at edge N. Also register tcc_in as t_q for edge detection.
- Stage 2 (edge N+1): decode each nibble into bin_out: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0. Binary count = concatenation of the decoded nibbles, nibble 0 = LSBs. Latency from gray_in to bin_out is 2 edges.
- Epoch:
  - Increment by 1 on each rising edge of tcc_in, i.e. tcc_in=1 and t_q=0 at the same edge.
  - Wraps from 2^EPW-1 to 0.
  - A level held high counts once.
- Capture:
  - When c_q=1 at edge N+1, push {e_q, decoded g_q} into the FIFO.
  - cap_valid rises at edge N+2, so the push is visible 2 edges after cap_req is sampled.
  - cap_req and a tcc_in rise on the same edge: the entry carries the pre-increment epoch with the terminal count value.
- FIFO:
  - DEPTH entries, first-word-fall-through. cap_data is valid whenever cap_valid=1 and is held stable until accepted.
  - Pop when cap_valid && cap_ready at an edge.
  - Push and pop at the same edge are both performed, including when full: the occupancy is unchanged and no overflow is raised.
  - Push while full without a same-edge pop: the entry is dropped, ovf is set, and existing contents are unchanged.
  - Push while empty: no bypass; cap_valid appears the following edge.
- ovf:
  - Sticky; cleared by ovf_clr at an edge.
  - If ovf_clr and a new overflow occur at the same edge, ovf stays 1.
- match:
  - Registered. match=1 for exactly one cycle on the edge after bin_out first becomes equal to cmp_val, detected by comparing the new value to the previous bin_out.
  - A bin_out that stays equal across cycles (counter not enabled) does not re-pulse.
  - A cmp_val change that makes it newly equal to a held bin_out pulses once.
- Reset mid-operation discards FIFO contents, epoch and pipeline contents immediately. The first capture after release behaves as from reset.
- No assumptions on gray_in validity: invalid or multi-bit nibble changes are decoded as-is.

Test Plan:
- Reset: hold clr, drive random gray_in/cap_req → all outputs 0; release → bin_out tracks gray_in after 2 edges.
- Decode: gray_in=20'h0_0_0_0_8 (nibble0 Gray 1000) → bin_out=20'h0000F. gray_in=20'h8_C_4_6_1 → bin_out=20'hF_8_7_4_1.
- Epoch: pulse tcc_in for 3 cycles, then low, 5 times; start at 254 via 254 prior pulses → epoch 255 then 0, 1, 2, 3. A capture issued after the sequence shows epoch=3.
- Simultaneous events: cap_req and tcc_in rise on the same edge, epoch=7, count Gray for 0x12345 → entry {7, 0x12345}. The next capture shows epoch 8.
- FIFO boundaries:
  - DEPTH=4, cap_ready=0, 5 captures → 4 entries, ovf=1.
  - Drain with cap_ready=1 → data in order, cap_valid drops after the 4th.
  - With the FIFO full, push and pop at the same edge → occupancy stays 4, ovf unchanged.
- Match: cmp_val=0x00010, counter incrementing → one match pulse one cycle after bin_out=0x00010. Hold counter at that value → no further pulses. ovf_clr clears ovf.
